// File: rtl/fir_tap_loader_pkg.sv
// fir_tap_loader_pkg: shared state encoding and sizing helper for the FIR tap loader.
// Revision: 1.0
`default_nettype none

package fir_tap_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int tap_count(input int log2);
        return 1 << log2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap_shadow_ram.sv
// fir_tap_shadow_ram: simple dual-port coefficient store, one write port, one registered read port.
// Revision: 1.0
`default_nettype none

module fir_tap_shadow_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: shadows all FIR coefficients and streams them to the FIR after a disable/flush.
// Optional macro FIR_TAP_LOADER_REVERSE_EN streams taps from T-1 down to 0.  Revision: 1.0
`default_nettype none

module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_FLUSH_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    input  logic                       cfg_wr_valid,
    output logic                       cfg_wr_err,
    input  logic                       load_start,
    output logic                       busy,
    output logic                       load_done,
    output logic                       taps_loaded,
    output logic                       fir_enable,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready
);

    localparam int C_AW  = G_NUM_TAPS_LOG2;
    localparam int C_T   = tap_count(G_NUM_TAPS_LOG2);
    localparam int C_FCW = (G_FLUSH_CYCLES > 1) ? $clog2(G_FLUSH_CYCLES) : 1;
    localparam logic [C_FCW-1:0] C_FLUSH_LAST = C_FCW'(G_FLUSH_CYCLES - 1);

`ifdef FIR_TAP_LOADER_REVERSE_EN
    localparam logic [C_AW-1:0] C_IDX_FIRST = C_AW'(C_T - 1);
    localparam logic [C_AW-1:0] C_IDX_LAST  = '0;
`else
    localparam logic [C_AW-1:0] C_IDX_FIRST = '0;
    localparam logic [C_AW-1:0] C_IDX_LAST  = C_AW'(C_T - 1);
`endif

    state_e             state_q;
    logic [C_FCW-1:0]   flush_cnt_q;
    logic [C_AW-1:0]    idx_q;
    logic               busy_q;
    logic               load_done_q;
    logic               wr_err_q;
    logic               taps_loaded_q;
    logic               fir_enable_q;
    logic               valid_q;

    logic               hs_d;
    logic               wr_ok_d;
    logic [C_AW-1:0]    idx_step_d;
    logic [C_AW-1:0]    rd_addr_d;

    assign hs_d    = valid_q & tap_dout_ready;
    assign wr_ok_d = cfg_wr_valid & ((state_q == ST_IDLE) | (state_q == ST_DONE));

`ifdef FIR_TAP_LOADER_REVERSE_EN
    assign idx_step_d = idx_q - C_AW'(1);
`else
    assign idx_step_d = idx_q + C_AW'(1);
`endif

    // Look one tap ahead on a handshake so the registered read keeps up at one tap per cycle;
    // outside STREAM the first tap is pre-read so it is ready on the first STREAM cycle.
    assign rd_addr_d = (state_q == ST_STREAM) ? (hs_d ? idx_step_d : idx_q) : C_IDX_FIRST;

    fir_tap_shadow_ram #(
        .ADDR_W (C_AW),
        .DATA_W (G_TAP_WIDTH)
    ) u_shadow_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok_d),
        .wr_addr_i (cfg_wr_addr),
        .wr_data_i (cfg_wr_data),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (tap_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            flush_cnt_q   <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            wr_err_q      <= 1'b0;
            taps_loaded_q <= 1'b0;
            fir_enable_q  <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            wr_err_q    <= cfg_wr_valid & ~wr_ok_d;
            case (state_q)
                ST_IDLE: begin
                    fir_enable_q <= 1'b0;
                    flush_cnt_q  <= '0;
                    if (load_start) begin
                        state_q       <= ST_FLUSH;
                        busy_q        <= 1'b1;
                        taps_loaded_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    fir_enable_q <= 1'b0;
                    flush_cnt_q  <= flush_cnt_q + C_FCW'(1);
                    if (flush_cnt_q == C_FLUSH_LAST) begin
                        state_q      <= ST_STREAM;
                        fir_enable_q <= 1'b1;
                        idx_q        <= C_IDX_FIRST;
                        valid_q      <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (hs_d) begin
                        idx_q <= idx_step_d;
                        if (idx_q == C_IDX_LAST) begin
                            state_q       <= ST_DONE;
                            valid_q       <= 1'b0;
                            busy_q        <= 1'b0;
                            load_done_q   <= 1'b1;
                            taps_loaded_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A new write makes the FIR's copy stale.
                    if (cfg_wr_valid) begin
                        taps_loaded_q <= 1'b0;
                    end
                    if (load_start) begin
                        state_q       <= ST_FLUSH;
                        busy_q        <= 1'b1;
                        taps_loaded_q <= 1'b0;
                        fir_enable_q  <= 1'b0;
                        flush_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_wr_err     = wr_err_q;
    assign busy           = busy_q;
    assign load_done      = load_done_q;
    assign taps_loaded    = taps_loaded_q;
    assign fir_enable     = fir_enable_q;
    assign tap_dout_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: directed scoreboard bench for fir_tap_loader.
// Revision: 1.0
`default_nettype none

module tb_fir_tap_loader;

    localparam int L = 4;
    localparam int W = 16;
    localparam int F = 2;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [L-1:0] cfg_wr_addr;
    logic [W-1:0] cfg_wr_data;
    logic         cfg_wr_valid;
    logic         cfg_wr_err;
    logic         load_start;
    logic         busy;
    logic         load_done;
    logic         taps_loaded;
    logic         fir_enable;
    logic [W-1:0] tap_dout;
    logic         tap_dout_valid;
    logic         tap_dout_ready;

    int           n_cmp = 0;
    int           n_err = 0;
    int           hs_cnt = 0;
    int           done_cnt = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] model [T];
    logic [W-1:0] held;
    bit           held_v = 1'b0;

    fir_tap_loader #(
        .G_NUM_TAPS_LOG2 (L),
        .G_TAP_WIDTH     (W),
        .G_FLUSH_CYCLES  (F)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_valid   (cfg_wr_valid),
        .cfg_wr_err     (cfg_wr_err),
        .load_start     (load_start),
        .busy           (busy),
        .load_done      (load_done),
        .taps_loaded    (taps_loaded),
        .fir_enable     (fir_enable),
        .tap_dout       (tap_dout),
        .tap_dout_valid (tap_dout_valid),
        .tap_dout_ready (tap_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks hold-under-backpressure.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && tap_dout_valid) check("hold_stable", tap_dout, held);
            if (load_done) done_cnt++;
            if (tap_dout_valid && tap_dout_ready) begin
                hs_cnt++;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("beat", tap_dout, e);
                held_v = 1'b0;
            end else if (tap_dout_valid) begin
                held_v = 1'b1;
                held   = tap_dout;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic wr(input int a, input logic [W-1:0] d);
        cfg_wr_addr  = L'(a);
        cfg_wr_data  = d;
        cfg_wr_valid = 1'b1;
        @(posedge clk); #1;
        cfg_wr_valid = 1'b0;
        model[a] = d;
    endtask

    task automatic push_exp();
        for (int i = 0; i < T; i++) begin
`ifdef FIR_TAP_LOADER_REVERSE_EN
            sb.push_back(model[T-1-i]);
`else
            sb.push_back(model[i]);
`endif
        end
    endtask

    task automatic start_and_flush();
        int lowc;
        int g;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("busy_after_start", busy, 1);
        lowc = 0;
        g = 0;
        while (!fir_enable && g < 20) begin
            lowc++;
            g++;
            @(posedge clk); #1;
        end
        check("flush_low_cycles", lowc, F);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input bit bp, input bit inject);
        int g;
        int d0;
        d0 = done_cnt;
        hs_cnt = 0;
        start_and_flush();
        g = 0;
        while (done_cnt == d0 && g < 400) begin
            tap_dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && g == 3) begin
                cfg_wr_addr  = 4'd3;
                cfg_wr_data  = 16'hDEAD;
                cfg_wr_valid = 1'b1;
            end
            @(posedge clk); #1;
            if (inject && g == 3) begin
                cfg_wr_valid = 1'b0;
                check("cfg_wr_err_pulse", cfg_wr_err, 1);
            end
            g++;
        end
        tap_dout_ready = 1'b0;
        check("load_no_timeout", (g < 400), 1);
        @(posedge clk); #1;
        check("load_done_once", done_cnt - d0, 1);
        check("handshakes", hs_cnt, T);
        check("sb_drained", sb.size(), 0);
        check("taps_loaded", taps_loaded, 1);
        check("busy_clear", busy, 0);
        check("fir_enable_on", fir_enable, 1);
        check("valid_off", tap_dout_valid, 0);
    endtask

    initial begin
        int g;
        reset          = 1'b1;
        cfg_wr_addr    = '0;
        cfg_wr_data    = '0;
        cfg_wr_valid   = 1'b0;
        load_start     = 1'b0;
        tap_dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_wr_err", cfg_wr_err, 0);
        check("rst_taps_loaded", taps_loaded, 0);
        check("rst_fir_enable", fir_enable, 0);
        check("rst_valid", tap_dout_valid, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic load with continuous ready
        for (int i = 0; i < T; i++) wr(i, 16'h0100 + 16'(i));
        check("idle_no_wr_err", cfg_wr_err, 0);
        push_exp();
        run_load(1'b0, 1'b0);

        // Reload under random backpressure with a rejected write mid-stream
        push_exp();
        run_load(1'b1, 1'b1);

        // Write in DONE makes the FIR stale, then reload
        wr(0, 16'hBEEF);
        check("stale_after_write", taps_loaded, 0);
        push_exp();
        run_load(1'b1, 1'b0);

        // Reset in the middle of a stream
        push_exp();
        hs_cnt = 0;
        start_and_flush();
        tap_dout_ready = 1'b1;
        g = 0;
        while (hs_cnt < 8 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("midstream_no_timeout", (g < 100), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", tap_dout_valid, 0);
        check("midrst_fir_enable", fir_enable, 0);
        check("midrst_busy", busy, 0);
        tap_dout_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        push_exp();
        run_load(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
